posit_pair_framer: RTL and testbench
====================================

POSIT_PAIR_FRAMER -- requirements
Module: posit_pair_framer

Interface
REQ-001 Parameter POSIT_WIDTH, default 16: width of one posit.
REQ-002 Parameter LOG_NB_ACCUM, default 15: log2 of the maximum dot-product window length.
REQ-003 Port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Weight slave stream on three ports: w_rts_i (input, 1), w_rtr_o (output, 1), w_data_i (input, POSIT_WIDTH).
REQ-006 Activation slave stream on three ports: a_rts_i (input, 1), a_rtr_o (output, 1), a_data_i (input, POSIT_WIDTH).
REQ-007 Port len_i, input, LOG_NB_ACCUM+1 bits: number of pairs in a window.
REQ-008 Master stream ports:
- rts_o (output, 1)
- rtr_i (input, 1)
- sow_o (output, 1)
- eow_o (output, 1)
- data_o (output, 2*POSIT_WIDTH)
REQ-009 Port busy_o, output, 1 bit: high while a window is open (at least one pair emitted and eow not yet emitted).

Function
REQ-010 A transfer on any stream occurs only in a cycle where its rts and rtr are both high.
REQ-011 Join rule: w_rtr_o = a_rts_i & in_ready, and a_rtr_o = w_rts_i & in_ready; a weight and an activation are therefore always consumed in the same cycle, never one alone.
REQ-012 in_ready is a registered signal, high exactly when the skid register is empty; the master-side rtr_i never reaches w_rtr_o or a_rtr_o combinationally.
REQ-013 Data packing: data_o[2*POSIT_WIDTH-1:POSIT_WIDTH] = weight and data_o[POSIT_WIDTH-1:0] = activation, both passed bit-exact.
REQ-014 Latency: a pair accepted in cycle t appears on data_o with rts_o high in cycle t+1, provided the output register is empty or draining.
REQ-015 Throughput: with rtr_i held high, one pair per cycle is sustained indefinitely.
REQ-016 Output buffering: one output register plus one skid register (2 entries).
- When the output register is stalled (rts_o & ~rtr_i) and a pair is accepted, the pair goes to the skid register.
- The skid register moves to the output register on the next transfer.
- Order is strictly FIFO.
REQ-017 While rts_o is high and rtr_i is low, data_o, sow_o and eow_o are held stable.
REQ-018 Beat counter cnt counts accepted pairs, range 0..len_q-1.
- When a pair is accepted with cnt==0, len_i is latched into len_q and the window opens.
- len_i is ignored at every other time.
REQ-019 Framing: an accepted pair is tagged sow=1 if cnt==0 and eow=1 if cnt==len_eff-1; after an eow pair, cnt wraps to 0.
- len_eff is len_i in the cycle of the cnt==0 accept.
- len_eff is len_q in all other cycles.
REQ-020 A len_i value of 0 is treated as 1: a single pair carries sow=1 and eow=1 together.
REQ-021 len_i = 2^LOG_NB_ACCUM is the maximum; the counter must not overflow at this length.
REQ-022 sow_o and eow_o are meaningful only while rts_o is high, and are driven 0 otherwise.
REQ-023 busy_o rises in the cycle after a sow pair is accepted that is not also eow, and falls in the cycle after an eow pair is accepted.

Reset
REQ-024 While rst_n is low at a clock edge, the following are cleared to 0: rts_o, sow_o, eow_o, data_o, busy_o, cnt, len_q, skid-valid and output-valid; in_ready is set to 1.
REQ-025 Reset asserted mid-window discards both buffered pairs, and the first pair accepted after reset is tagged sow=1.
REQ-026 While rst_n is low, w_rtr_o and a_rtr_o are driven 0.

Structure
REQ-027 The pair-word field positions (weight MSB half, activation LSB half) are defined in posit_defines, so posit_pair_framer and positron_wo_delay_weights share one definition.
REQ-028 The 2-entry output buffer is a separate sub-module, skid_buffer, parameterised by DATA_WIDTH and carrying data, sow and eow; counting and join logic stay in posit_pair_framer.

Verification
REQ-029 Stimulus: len_i=4; both inputs valid every cycle; rtr_i=1; weights 0x4000..0x4003; activations 0x3000..0x3003. Required: data_o = 0x40003000..0x40033003 on 4 consecutive cycles starting 1 cycle after the first accept; sow on beat 0 only; eow on beat 3 only.
REQ-030 Stimulus: w_rts_i=1 with a_rts_i=0 for 5 cycles, then a_rts_i=1. Required: w_rtr_o=0 during the 5 cycles, no output; the first pair appears exactly 1 cycle after a_rts_i rises.
REQ-031 Stimulus: len_i=3; rtr_i dropped for 3 cycles mid-window. Required: accepts stop after at most 2 buffered pairs; data is held stable; after rtr_i rises, the pairs emerge in order with eow on the third.
REQ-032 Stimulus: len_i=0, then len_i=1. Required: every output beat has sow=1 and eow=1; busy_o stays 0.
REQ-033 Stimulus: len_i changed from 4 to 2 at beat 2 of a 4-window. Required: the current window still ends at beat 3; the next window has length 2.
REQ-034 Stimulus: rst_n pulsed low for 1 cycle at beat 1 of a len 4 window. Required: rts_o=0 the next cycle; the next accepted pair carries sow=1.

Source files
------------

// File: rtl/posit_defines.sv
// Definitions shared by the posit datapath blocks: where weight and activation sit in a pair word,
// and the framing tag that travels with each pair.
package posit_defines;

  // Each index selects one POSIT_WIDTH-wide half of a pair word.
  localparam int WEIGHT_HALF = 1;
  localparam int ACT_HALF    = 0;

  typedef struct packed {
    logic sow;
    logic eow;
  } frame_tag_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry output buffer made of an output register and a skid register.
// in_ready is registered, so the downstream ready never reaches the upstream ready in the same cycle.
module skid_buffer
  import posit_defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sow,
  input  logic                  in_eow,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sow,
  output logic                  out_eow
);

  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  frame_tag_t            out_tag_q;
  frame_tag_t            skid_tag_q;
  logic                  out_valid_q;
  logic                  skid_valid_q;
  logic                  out_fire;

  assign out_fire = out_valid_q & out_ready;

  // The caller presents in_valid only while in_ready is high, so a new entry never meets a full skid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      skid_data_q  <= '0;
      out_tag_q    <= '0;
      skid_tag_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready     <= 1'b1;
    end else if (skid_valid_q) begin
      if (out_fire) begin
        out_data_q   <= skid_data_q;
        out_tag_q    <= skid_tag_q;
        skid_valid_q <= 1'b0;
        in_ready     <= 1'b1;
      end
    end else if (in_valid) begin
      if (out_valid_q && !out_ready) begin
        skid_data_q  <= in_data;
        skid_tag_q   <= '{sow: in_sow, eow: in_eow};
        skid_valid_q <= 1'b1;
        in_ready     <= 1'b0;
      end else begin
        out_data_q  <= in_data;
        out_tag_q   <= '{sow: in_sow, eow: in_eow};
        out_valid_q <= 1'b1;
      end
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sow   = out_valid_q & out_tag_q.sow;
  assign out_eow   = out_valid_q & out_tag_q.eow;

endmodule

// File: rtl/posit_pair_framer.sv
// Joins a weight stream and an activation stream into pair words and frames them into
// dot-product windows of len_i pairs, marking the first (sow) and last (eow) pair.
module posit_pair_framer
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH  = 16,
  parameter int LOG_NB_ACCUM = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_rts_i,
  output logic                     w_rtr_o,
  input  logic [POSIT_WIDTH-1:0]   w_data_i,
  input  logic                     a_rts_i,
  output logic                     a_rtr_o,
  input  logic [POSIT_WIDTH-1:0]   a_data_i,
  input  logic [LOG_NB_ACCUM:0]    len_i,
  output logic                     rts_o,
  input  logic                     rtr_i,
  output logic                     sow_o,
  output logic                     eow_o,
  output logic [2*POSIT_WIDTH-1:0] data_o,
  output logic                     busy_o
);

  localparam int LEN_W = LOG_NB_ACCUM + 1;

  logic                     in_ready;
  logic                     accept;
  logic [LEN_W-1:0]         cnt;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         len_eff;
  logic [LEN_W-1:0]         len_fix;
  logic                     is_sow;
  logic                     is_eow;
  logic [2*POSIT_WIDTH-1:0] pair_word;

  // Each side's ready depends on the other side's valid, so both are consumed together or not at all.
  assign w_rtr_o = rst_n & a_rts_i & in_ready;
  assign a_rtr_o = rst_n & w_rts_i & in_ready;
  assign accept  = w_rts_i & w_rtr_o;

  always_comb begin
    pair_word = '0;
    pair_word[WEIGHT_HALF*POSIT_WIDTH +: POSIT_WIDTH] = w_data_i;
    pair_word[ACT_HALF*POSIT_WIDTH +: POSIT_WIDTH]    = a_data_i;
  end

  // len_i only matters on the opening beat; a zero length is treated as a one-pair window.
  always_comb begin
    len_eff = (cnt == '0) ? len_i : len_q;
    len_fix = (len_eff == '0) ? LEN_W'(1) : len_eff;
    is_sow  = (cnt == '0);
    is_eow  = (cnt == len_fix - LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      len_q  <= '0;
      busy_o <= 1'b0;
    end else if (accept) begin
      if (is_sow) begin
        len_q <= len_fix;
      end
      cnt    <= is_eow ? '0 : cnt + LEN_W'(1);
      busy_o <= ~is_eow;
    end
  end

  skid_buffer #(
    .DATA_WIDTH (2*POSIT_WIDTH)
  ) u_skid_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_data   (pair_word),
    .in_sow    (is_sow),
    .in_eow    (is_eow),
    .in_ready  (in_ready),
    .out_valid (rts_o),
    .out_ready (rtr_i),
    .out_data  (data_o),
    .out_sow   (sow_o),
    .out_eow   (eow_o)
  );

endmodule

// File: tb/tb_posit_pair_framer.sv
// Directed bench for posit_pair_framer: a per-cycle vector table for the streaming cases plus
// hand-written sequences for join stalls, back-pressure, maximum window length and mid-window reset.
module tb_posit_pair_framer;

  localparam int PW = 16;
  localparam int LA = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            w_rts_i, a_rts_i, rtr_i;
  logic [PW-1:0]   w_data_i, a_data_i;
  logic [LA:0]     len_i;
  logic            w_rtr_o, a_rtr_o, rts_o, sow_o, eow_o, busy_o;
  logic [2*PW-1:0] data_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        w_rts;
    logic        a_rts;
    logic [15:0] w;
    logic [15:0] a;
    logic [15:0] len;
    logic        rtr;
    logic        x_rts;
    logic [31:0] x_data;
    logic        x_sow;
    logic        x_eow;
    logic        x_busy;
  } vec_t;

  vec_t vecs[$];

  posit_pair_framer #(.POSIT_WIDTH(PW), .LOG_NB_ACCUM(LA)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_rts_i  (w_rts_i),
    .w_rtr_o  (w_rtr_o),
    .w_data_i (w_data_i),
    .a_rts_i  (a_rts_i),
    .a_rtr_o  (a_rtr_o),
    .a_data_i (a_data_i),
    .len_i    (len_i),
    .rts_o    (rts_o),
    .rtr_i    (rtr_i),
    .sow_o    (sow_o),
    .eow_o    (eow_o),
    .data_o   (data_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic av, input logic [15:0] w, input logic [15:0] a,
                               input logic [15:0] len, input logic rtr);
    w_rts_i  = wv;
    a_rts_i  = av;
    w_data_i = w;
    a_data_i = a;
    len_i    = len;
    rtr_i    = rtr;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic wv, input logic av, input logic [15:0] w, input logic [15:0] a,
                        input logic [15:0] len, input logic xr, input logic [31:0] xd,
                        input logic xs, input logic xe, input logic xb);
    vec_t v;
    v.w_rts = wv; v.a_rts = av; v.w = w; v.a = a; v.len = len; v.rtr = 1'b1;
    v.x_rts = xr; v.x_data = xd; v.x_sow = xs; v.x_eow = xe; v.x_busy = xb;
    vecs.push_back(v);
  endtask

  initial begin
    int sow_cnt;
    int eow_at;
    int beats;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h0, 16'h0, 16'd4, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("reset_rts", 32'(rts_o), 32'd0);
    checkOutput("reset_data", data_o, 32'd0);
    checkOutput("reset_sow_eow", {30'd0, sow_o, eow_o}, 32'd0);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_w_rtr", 32'(w_rtr_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'd4, 1'b1);
    rst_n = 1'b1;
    stepCycle();

    // Basic 4-window, one pair per cycle.
    addVec(1, 1, 16'h4000, 16'h3000, 16'd4, 1, 32'h40003000, 1, 0, 1);
    addVec(1, 1, 16'h4001, 16'h3001, 16'd4, 1, 32'h40013001, 0, 0, 1);
    addVec(1, 1, 16'h4002, 16'h3002, 16'd4, 1, 32'h40023002, 0, 0, 1);
    addVec(1, 1, 16'h4003, 16'h3003, 16'd4, 1, 32'h40033003, 0, 1, 0);
    addVec(0, 0, 16'h0,    16'h0,    16'd4, 0, 32'h0,        0, 0, 0);
    // Length 0 and 1: every beat is both sow and eow.
    addVec(1, 1, 16'h1111, 16'h2222, 16'd0, 1, 32'h11112222, 1, 1, 0);
    addVec(1, 1, 16'h1234, 16'h5678, 16'd1, 1, 32'h12345678, 1, 1, 0);
    addVec(1, 1, 16'hABCD, 16'hEF01, 16'd0, 1, 32'hABCDEF01, 1, 1, 0);
    addVec(0, 0, 16'h0,    16'h0,    16'd1, 0, 32'h0,        0, 0, 0);
    // len_i changes mid-window: the open window keeps length 4, the next one takes 2.
    addVec(1, 1, 16'h5000, 16'h6000, 16'd4, 1, 32'h50006000, 1, 0, 1);
    addVec(1, 1, 16'h5001, 16'h6001, 16'd4, 1, 32'h50016001, 0, 0, 1);
    addVec(1, 1, 16'h5002, 16'h6002, 16'd2, 1, 32'h50026002, 0, 0, 1);
    addVec(1, 1, 16'h5003, 16'h6003, 16'd2, 1, 32'h50036003, 0, 1, 0);
    addVec(1, 1, 16'h7000, 16'h8000, 16'd2, 1, 32'h70008000, 1, 0, 1);
    addVec(1, 1, 16'h7001, 16'h8001, 16'd2, 1, 32'h70018001, 0, 1, 0);
    addVec(0, 0, 16'h0,    16'h0,    16'd2, 0, 32'h0,        0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].w_rts, vecs[i].a_rts, vecs[i].w, vecs[i].a, vecs[i].len, vecs[i].rtr);
      stepCycle();
      checkOutput($sformatf("vec%0d_rts", i), 32'(rts_o), 32'(vecs[i].x_rts));
      if (vecs[i].x_rts) begin
        checkOutput($sformatf("vec%0d_data", i), data_o, vecs[i].x_data);
        checkOutput($sformatf("vec%0d_sow", i), 32'(sow_o), 32'(vecs[i].x_sow));
        checkOutput($sformatf("vec%0d_eow", i), 32'(eow_o), 32'(vecs[i].x_eow));
      end else begin
        checkOutput($sformatf("vec%0d_sow_eow_idle", i), {30'd0, sow_o, eow_o}, 32'd0);
      end
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vecs[i].x_busy));
    end

    // Weight waits alone for 5 cycles; nothing is consumed until the activation arrives.
    applyStimulus(1'b1, 1'b0, 16'h4100, 16'h3100, 16'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("join_w_rtr_%0d", i), 32'(w_rtr_o), 32'd0);
      stepCycle();
      checkOutput($sformatf("join_no_out_%0d", i), 32'(rts_o), 32'd0);
    end
    a_rts_i = 1'b1;
    @(negedge clk);
    checkOutput("join_both_rtr", {30'd0, w_rtr_o, a_rtr_o}, 32'd3);
    stepCycle();
    checkOutput("join_first_rts", 32'(rts_o), 32'd1);
    checkOutput("join_first_data", data_o, 32'h41003100);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'd3, 1'b1);
    stepCycle();

    // Back-pressure in a 3-window: at most two pairs buffered, output held, order kept.
    applyStimulus(1'b1, 1'b1, 16'h4200, 16'h3200, 16'd3, 1'b1);
    stepCycle();
    checkOutput("bp_p0_data", data_o, 32'h42003200);
    applyStimulus(1'b1, 1'b1, 16'h4201, 16'h3201, 16'd3, 1'b0);
    stepCycle();
    checkOutput("bp_held_b_data", data_o, 32'h42003200);
    checkOutput("bp_held_b_sow", 32'(sow_o), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h4202, 16'h3202, 16'd3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_full_w_rtr_%0d", i), 32'(w_rtr_o), 32'd0);
      stepCycle();
      checkOutput($sformatf("bp_held_data_%0d", i), data_o, 32'h42003200);
      checkOutput($sformatf("bp_held_rts_%0d", i), 32'(rts_o), 32'd1);
    end
    rtr_i = 1'b1;
    stepCycle();
    checkOutput("bp_p1_data", data_o, 32'h42013201);
    checkOutput("bp_p1_tags", {30'd0, sow_o, eow_o}, 32'd0);
    stepCycle();
    checkOutput("bp_p2_data", data_o, 32'h42023202);
    checkOutput("bp_p2_eow", 32'(eow_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'd3, 1'b1);
    stepCycle();
    checkOutput("bp_drained", 32'(rts_o), 32'd0);
    checkOutput("bp_busy", 32'(busy_o), 32'd0);

    // Maximum window length 2^LOG_NB_ACCUM.
    sow_cnt = 0;
    eow_at  = -1;
    beats   = 0;
    applyStimulus(1'b1, 1'b1, 16'h0, 16'h0, 16'h8000, 1'b1);
    for (int i = 0; i < 32768; i++) begin
      w_data_i = 16'(i);
      stepCycle();
      if (rts_o) beats++;
      if (sow_o) sow_cnt++;
      if (eow_o && eow_at < 0) eow_at = i;
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'd4, 1'b1);
    checkOutput("max_beats", 32'(beats), 32'd32768);
    checkOutput("max_sow_count", 32'(sow_cnt), 32'd1);
    checkOutput("max_eow_beat", 32'(eow_at), 32'd32767);
    stepCycle();
    checkOutput("max_busy_after", 32'(busy_o), 32'd0);

    // Reset pulsed at beat 1 of a 4-window.
    applyStimulus(1'b1, 1'b1, 16'h4300, 16'h3300, 16'd4, 1'b1);
    stepCycle();
    checkOutput("rst_p0_sow", 32'(sow_o), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h4301, 16'h3301, 16'd4, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_rtr_gated", {30'd0, w_rtr_o, a_rtr_o}, 32'd0);
    stepCycle();
    checkOutput("rst_rts_cleared", 32'(rts_o), 32'd0);
    checkOutput("rst_busy_cleared", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h4400, 16'h3400, 16'd4, 1'b1);
    stepCycle();
    checkOutput("rst_next_data", data_o, 32'h44003400);
    checkOutput("rst_next_sow", 32'(sow_o), 32'd1);
    checkOutput("rst_next_busy", 32'(busy_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 16'd4, 1'b1);
    stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
